// File: rtl/ofs_asp_host_rd_arb_if.sv
// ofs_asp_host_rd_arb_if
//   Avalon-MM read channel between the ASP read arbiter and host memory
//   (PIM host_mem_to_afu read side).
//
//   master modport : arbiter side, drives the command and receives responses
//   slave  modport : host-memory side
//
//   host_read          command valid
//   host_address       byte address
//   host_burstcount    burst length in beats
//   host_waitrequest   command stall
//   host_readdata      response beat
//   host_readdatavalid response valid (no backpressure)
interface ofs_asp_host_rd_arb_if #(
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6
);
    logic                       host_read;
    logic [ADDR_WIDTH-1:0]      host_address;
    logic [BURST_CNT_WIDTH-1:0] host_burstcount;
    logic                       host_waitrequest;
    logic [DATA_WIDTH-1:0]      host_readdata;
    logic                       host_readdatavalid;

    modport master (
        output host_read, host_address, host_burstcount,
        input  host_waitrequest, host_readdata, host_readdatavalid
    );

    modport slave (
        input  host_read, host_address, host_burstcount,
        output host_waitrequest, host_readdata, host_readdatavalid
    );
endinterface

// File: rtl/ofs_asp_host_rd_arb.sv
// ofs_asp_host_rd_arb
//   Round-robin arbiter sharing the host-memory read channel among NUM_REQ
//   ASP requesters. One burst command is forwarded per acceptance; the owner
//   and length of every accepted burst are queued in an in-order tracking
//   FIFO so the in-order read responses can be steered back to the owner.
//
//   Ports:
//     pClk, pClk_reset     clock, synchronous active-high reset
//     req_read/address/burstcount/waitrequest   per-requester command port
//     req_readdatavalid    one-hot response valid (one cycle after host beat)
//     req_readdata         response data, broadcast to all requesters
//     host                 downstream read channel (interface, master side)
//     err_unexpected_rsp   sticky: a response arrived with nothing outstanding
//     stat_bursts          per-requester accepted-burst counters (32b each)
//     stat_stall_cycles    cycles with a request pending but nothing accepted
//
//   Optional feature macro: OFS_ASP_HOST_RD_ARB_STATS_EN enables the stat_*
//   counters; when undefined they are tied to zero.
module ofs_asp_host_rd_arb #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6,
    parameter int TRK_DEPTH       = 64
) (
    input  logic                               pClk,
    input  logic                               pClk_reset,
    input  logic [NUM_REQ-1:0]                 req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_address,
    input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0] req_burstcount,
    output logic [NUM_REQ-1:0]                 req_waitrequest,
    output logic [NUM_REQ-1:0]                 req_readdatavalid,
    output logic [DATA_WIDTH-1:0]              req_readdata,
    ofs_asp_host_rd_arb_if.master              host,
    output logic                               err_unexpected_rsp,
    output logic [NUM_REQ*32-1:0]              stat_bursts,
    output logic [31:0]                        stat_stall_cycles
);
    localparam int RR_W    = $clog2(NUM_REQ);
    localparam int PTR_W   = $clog2(TRK_DEPTH);
    localparam int ENTRY_W = RR_W + BURST_CNT_WIDTH;

    logic [ADDR_WIDTH-1:0]      addr_arr [NUM_REQ];
    logic [BURST_CNT_WIDTH-1:0] bc_arr   [NUM_REQ];

    logic [RR_W-1:0]            rr_reg, rr_next, winner;
    logic                       found;
    int                         idx;
    logic                       any_req, accept, push, pop, rsp_valid, beat_last;
    logic                       trk_full, trk_empty;

    // Tracking FIFO. The head entry is read asynchronously because the
    // response beat must be steered in the same cycle it arrives.
    logic [ENTRY_W-1:0]         trk_mem [TRK_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]             cnt_reg;
    logic [RR_W-1:0]            head_id;
    logic [BURST_CNT_WIDTH-1:0] head_bc;
    logic [BURST_CNT_WIDTH-1:0] beat_cnt_reg, beat_cnt_next;

    logic [NUM_REQ-1:0]         rdv_reg, rdv_next;
    logic [DATA_WIDTH-1:0]      rdata_reg;
    logic                       err_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi] = req_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign bc_arr[gi]   = req_burstcount[gi*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
            // Only the current winner may see its stall drop.
            assign req_waitrequest[gi] = (winner != RR_W'(gi)) | host.host_waitrequest | trk_full;
        end
    endgenerate

    // Winner: first requesting index at or above rr, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_read[idx[RR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[RR_W-1:0];
            end
        end
    end

    assign rr_next   = (winner == RR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign any_req   = |req_read;
    assign trk_full  = (cnt_reg == (PTR_W+1)'(TRK_DEPTH));
    assign trk_empty = (cnt_reg == '0);

    assign host.host_read       = any_req & ~trk_full;
    assign host.host_address    = addr_arr[winner];
    assign host.host_burstcount = bc_arr[winner];

    // host_read is already gated by trk_full, so a full FIFO never pushes
    // even when a pop happens in the same cycle.
    assign accept = host.host_read & ~host.host_waitrequest;
    assign push   = accept;

    assign {head_id, head_bc} = trk_mem[rd_ptr_reg];
    assign rsp_valid = host.host_readdatavalid & ~trk_empty;
    assign beat_last = (BURST_CNT_WIDTH'(beat_cnt_reg + 1'b1) == head_bc);
    assign pop       = rsp_valid & beat_last;

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        rdv_next      = '0;
        if (rsp_valid) begin
            beat_cnt_next     = beat_last ? '0 : beat_cnt_reg + 1'b1;
            rdv_next[head_id] = 1'b1;
        end
    end

    always_ff @(posedge pClk) begin
        if (push) trk_mem[wr_ptr_reg] <= {winner, bc_arr[winner]};
    end

    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            rr_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            beat_cnt_reg <= '0;
            rdv_reg      <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) rr_reg <= rr_next;
            if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
            beat_cnt_reg <= beat_cnt_next;
            rdv_reg      <= rdv_next;
            rdata_reg    <= host.host_readdata;
            // Beats with nothing outstanding (including leftovers from
            // before a reset) are dropped and flagged.
            err_reg      <= err_reg | (host.host_readdatavalid & trk_empty);
        end
    end

    assign req_readdatavalid  = rdv_reg;
    assign req_readdata       = rdata_reg;
    assign err_unexpected_rsp = err_reg;

`ifdef OFS_ASP_HOST_RD_ARB_STATS_EN
    logic [31:0] bursts_reg [NUM_REQ];
    logic [31:0] stall_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
            always_ff @(posedge pClk) begin
                if (pClk_reset)                          bursts_reg[gi] <= '0;
                else if (accept && winner == RR_W'(gi))  bursts_reg[gi] <= bursts_reg[gi] + 1'b1;
            end
            assign stat_bursts[gi*32 +: 32] = bursts_reg[gi];
        end
    endgenerate

    always_ff @(posedge pClk) begin
        if (pClk_reset)            stall_reg <= '0;
        else if (any_req & ~accept) stall_reg <= stall_reg + 1'b1;
    end
    assign stat_stall_cycles = stall_reg;
`else
    assign stat_bursts       = '0;
    assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_ofs_asp_host_rd_arb.sv
module tb_ofs_asp_host_rd_arb;
    localparam int NR = 4;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int BW = 6;
    localparam int TD = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NR-1:0]      req_read;
    logic [NR*AW-1:0]   req_address;
    logic [NR*BW-1:0]   req_burstcount;
    wire  [NR-1:0]      req_waitrequest;
    wire  [NR-1:0]      req_readdatavalid;
    wire  [DW-1:0]      req_readdata;
    wire                err_unexpected_rsp;
    wire  [NR*32-1:0]   stat_bursts;
    wire  [31:0]        stat_stall_cycles;

    ofs_asp_host_rd_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW)) hb ();

    ofs_asp_host_rd_arb #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .BURST_CNT_WIDTH(BW), .TRK_DEPTH(TD)
    ) dut (
        .pClk               (clk),
        .pClk_reset         (rst),
        .req_read           (req_read),
        .req_address        (req_address),
        .req_burstcount     (req_burstcount),
        .req_waitrequest    (req_waitrequest),
        .req_readdatavalid  (req_readdatavalid),
        .req_readdata       (req_readdata),
        .host               (hb.master),
        .err_unexpected_rsp (err_unexpected_rsp),
        .stat_bursts        (stat_bursts),
        .stat_stall_cycles  (stat_stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding bursts as (owner, beats left) queues.
    int            m_rr;
    int            m_own_q[$];
    int            m_rem_q[$];
    int            m_acc;
    logic [NR-1:0] exp_rdv;
    logic [DW-1:0] exp_data;
    logic          exp_err;

    function automatic int model_winner();
        for (int k = 0; k < NR; k++) begin
            if (req_read[(m_rr + k) % NR]) return (m_rr + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_address[i*AW +: AW];
    endfunction

    function automatic logic [BW-1:0] bc_of(input int i);
        return req_burstcount[i*BW +: BW];
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input int bc);
        req_address[i*AW +: AW]    = a;
        req_burstcount[i*BW +: BW] = BW'(bc);
        req_read[i]                = 1'b1;
    endtask

    // Advance one clock, updating the model from the inputs present now.
    task automatic cycle();
        int  w;
        bit  acc;
        w   = model_winner();
        acc = (w >= 0) && (m_own_q.size() < TD) && !hb.host_waitrequest;
        exp_rdv  = '0;
        exp_data = hb.host_readdata;
        if (hb.host_readdatavalid) begin
            if (m_own_q.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                exp_rdv[m_own_q[0]] = 1'b1;
                m_rem_q[0] = m_rem_q[0] - 1;
                if (m_rem_q[0] == 0) begin
                    void'(m_own_q.pop_front());
                    void'(m_rem_q.pop_front());
                end
            end
        end
        if (acc) begin
            m_own_q.push_back(w);
            m_rem_q.push_back(int'(bc_of(w)));
            m_rr = (w + 1) % NR;
            $display("burst accepted req=%0d addr=%h bc=%0d", w, addr_of(w), bc_of(w));
        end
        m_acc = acc ? w : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_read = '0;
        req_address = '0;
        req_burstcount = '0;
        hb.host_waitrequest   = 1'b0;
        hb.host_readdatavalid = 1'b0;
        hb.host_readdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_rr = 0;
        m_own_q.delete();
        m_rem_q.delete();
        m_acc = -1;
        exp_rdv = '0;
        exp_data = '0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_readdatavalid !== 4'b0) begin errors++; $display("FAIL reset_rdv got %b exp 0", req_readdatavalid); end
        checks++; if (req_readdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", req_readdata); end
        checks++; if (err_unexpected_rsp !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_unexpected_rsp); end
        checks++; if (hb.host_read !== 1'b0) begin errors++; $display("FAIL reset_host_read got %b exp 0", hb.host_read); end
        checks++; if (stat_bursts !== '0 || stat_stall_cycles !== '0) begin errors++; $display("FAIL reset_stats got %h/%h exp 0", stat_bursts, stat_stall_cycles); end
    endtask

    task automatic test_single_req();
        do_reset();
        set_req(2, 48'h1000, 8);
        #1;
        checks++; if (hb.host_read !== 1'b1) begin errors++; $display("FAIL single_host_read got %b exp 1", hb.host_read); end
        checks++; if (hb.host_address !== 48'h1000) begin errors++; $display("FAIL single_addr got %h exp 1000", hb.host_address); end
        checks++; if (hb.host_burstcount !== 6'd8) begin errors++; $display("FAIL single_bc got %0d exp 8", hb.host_burstcount); end
        checks++; if (req_waitrequest !== 4'b1011) begin errors++; $display("FAIL single_wr got %b exp 1011", req_waitrequest); end
        cycle();
        req_read = '0;
        for (int b = 0; b < 8; b++) begin
            hb.host_readdatavalid = 1'b1;
            hb.host_readdata = {$urandom, $urandom};
            cycle();
            checks++; if (req_readdatavalid !== 4'b0100 || req_readdata !== exp_data) begin
                errors++; $display("FAIL single_beat%0d got %b/%h exp 0100/%h", b, req_readdatavalid, req_readdata, exp_data); end
        end
        // FIFO must now be empty: a further beat is unexpected.
        cycle();
        hb.host_readdatavalid = 1'b0;
        checks++; if (req_readdatavalid !== 4'b0 || err_unexpected_rsp !== 1'b1) begin
            errors++; $display("FAIL single_empty got %b/%b exp 0000/1", req_readdatavalid, err_unexpected_rsp); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, AW'(48'h40 + i * 48'h100), 1);
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (hb.host_address !== addr_of(k % NR) || req_waitrequest !== ~(4'b0001 << (k % NR))) begin
                errors++; $display("FAIL rr_grant%0d got %h/%b exp %h/%b", k, hb.host_address, req_waitrequest, addr_of(k % NR), ~(4'b0001 << (k % NR))); end
            cycle();
        end
        req_read = '0;
        for (int k = 0; k < 12; k++) begin
            hb.host_readdatavalid = 1'b1;
            hb.host_readdata = {$urandom, $urandom};
            cycle();
            checks++; if (req_readdatavalid !== (4'b0001 << (k % NR))) begin
                errors++; $display("FAIL rr_rsp%0d got %b exp %b", k, req_readdatavalid, 4'b0001 << (k % NR)); end
        end
        hb.host_readdatavalid = 1'b0;
    endtask

    task automatic test_stall_hold();
        int seq[4] = '{0, 1, 1, 3};
        do_reset();
        set_req(0, 48'hA000, 1);
        #1;
        cycle();                       // req 0 accepted, rr -> 1
        set_req(1, 48'hB000, 2);
        hb.host_waitrequest = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (hb.host_address !== 48'hB000 || req_waitrequest !== 4'hF || hb.host_read !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d got %h/%b exp B000/1111", c, hb.host_address, req_waitrequest); end
            cycle();
        end
        hb.host_waitrequest = 1'b0;
        #1;
        checks++; if (req_waitrequest !== 4'b1101) begin errors++; $display("FAIL stall_release got %b exp 1101", req_waitrequest); end
        cycle();                       // req 1 accepted, rr -> 2
        req_read[1] = 1'b0;
        set_req(3, 48'hC000, 1);
        #1;
        checks++; if (hb.host_address !== 48'hC000) begin errors++; $display("FAIL stall_rr2 got %h exp C000", hb.host_address); end
        cycle();
        req_read = '0;
        for (int b = 0; b < 4; b++) begin
            hb.host_readdatavalid = 1'b1;
            cycle();
            checks++; if (req_readdatavalid !== (4'b0001 << seq[b])) begin
                errors++; $display("FAIL stall_rsp%0d got %b exp %b", b, req_readdatavalid, 4'b0001 << seq[b]); end
        end
        hb.host_readdatavalid = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        set_req(0, 48'h2000, 1);
        repeat (TD) cycle();
        #1;
        checks++; if (hb.host_read !== 1'b0 || req_waitrequest !== 4'hF) begin
            errors++; $display("FAIL full_stall got %b/%b exp 0/1111", hb.host_read, req_waitrequest); end
        cycle();
        hb.host_readdatavalid = 1'b1;
        #1;
        checks++; if (hb.host_read !== 1'b0) begin errors++; $display("FAIL full_pop_cycle got %b exp 0", hb.host_read); end
        cycle();
        hb.host_readdatavalid = 1'b0;
        #1;
        checks++; if (req_readdatavalid !== 4'b0001) begin errors++; $display("FAIL full_rsp got %b exp 0001", req_readdatavalid); end
        checks++; if (hb.host_read !== 1'b1 || req_waitrequest[0] !== 1'b0) begin
            errors++; $display("FAIL full_push_next got %b/%b exp 1/0", hb.host_read, req_waitrequest[0]); end
        cycle();
        #1;
        checks++; if (hb.host_read !== 1'b0) begin errors++; $display("FAIL full_again got %b exp 0", hb.host_read); end
        req_read = '0;
    endtask

    task automatic test_interleave();
        int own;
        do_reset();
        set_req(0, 48'h3000, 4);  #1; cycle(); req_read = '0;
        set_req(3, 48'h4000, 32); #1; cycle(); req_read = '0;
        set_req(1, 48'h5000, 1);  #1; cycle(); req_read = '0;
        for (int b = 0; b < 37; b++) begin
            own = (b < 4) ? 0 : (b < 36) ? 3 : 1;
            hb.host_readdatavalid = 1'b1;
            hb.host_readdata = {$urandom, $urandom};
            cycle();
            checks++; if (req_readdatavalid !== (4'b0001 << own) || req_readdata !== exp_data || err_unexpected_rsp !== 1'b0) begin
                errors++; $display("FAIL ilv_beat%0d got %b/%b exp %b/0", b, req_readdatavalid, err_unexpected_rsp, 4'b0001 << own); end
        end
        cycle();                       // 38th beat: nothing outstanding
        hb.host_readdatavalid = 1'b0;
        checks++; if (req_readdatavalid !== 4'b0 || err_unexpected_rsp !== 1'b1) begin
            errors++; $display("FAIL ilv_extra got %b/%b exp 0000/1", req_readdatavalid, err_unexpected_rsp); end
        repeat (3) cycle();
        checks++; if (err_unexpected_rsp !== 1'b1) begin errors++; $display("FAIL ilv_sticky got %b exp 1", err_unexpected_rsp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 48'h6000, 4); #1; cycle(); cycle(); req_read = '0;
        hb.host_readdatavalid = 1'b1; cycle(); hb.host_readdatavalid = 1'b0;
        do_reset();
        hb.host_readdatavalid = 1'b1;
        cycle();
        hb.host_readdatavalid = 1'b0;
        checks++; if (req_readdatavalid !== 4'b0 || err_unexpected_rsp !== 1'b1) begin
            errors++; $display("FAIL midrst_drop got %b/%b exp 0000/1", req_readdatavalid, err_unexpected_rsp); end
    endtask

    task automatic test_stats();
        logic [31:0] e0, e2, es;
        do_reset();
        set_req(0, 48'h7000, 1);
        repeat (10) cycle();
        req_read = '0;
        set_req(2, 48'h8000, 2);
        hb.host_waitrequest = 1'b1;
        repeat (3) cycle();
        hb.host_waitrequest = 1'b0;
        repeat (3) cycle();
        req_read = '0;
        cycle();
`ifdef OFS_ASP_HOST_RD_ARB_STATS_EN
        e0 = 32'd10; e2 = 32'd3; es = 32'd3;
`else
        e0 = 32'd0;  e2 = 32'd0; es = 32'd0;
`endif
        checks++; if (stat_bursts[0 +: 32] !== e0) begin errors++; $display("FAIL stat_req0 got %0d exp %0d", stat_bursts[0 +: 32], e0); end
        checks++; if (stat_bursts[64 +: 32] !== e2) begin errors++; $display("FAIL stat_req2 got %0d exp %0d", stat_bursts[64 +: 32], e2); end
        checks++; if (stat_bursts[32 +: 32] !== 32'd0 || stat_bursts[96 +: 32] !== 32'd0) begin
            errors++; $display("FAIL stat_idle got %h exp 0", stat_bursts); end
        checks++; if (stat_stall_cycles !== es) begin errors++; $display("FAIL stat_stall got %0d exp %0d", stat_stall_cycles, es); end
    endtask

    task automatic test_random();
        int            w, outstanding;
        logic [NR-1:0] ewr;
        bit            efull;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_read[i] && ($urandom % 3 == 0))
                    set_req(i, AW'({$urandom} << 6), int'($urandom_range(1, 32)));
            end
            outstanding = 0;
            foreach (m_rem_q[j]) outstanding += m_rem_q[j];
            hb.host_waitrequest   = ($urandom % 4 == 0);
            hb.host_readdatavalid = (outstanding > 0) && ($urandom % 2 == 0);
            hb.host_readdata      = {$urandom, $urandom};
            #1;
            w = model_winner();
            efull = (m_own_q.size() >= TD);
            checks++; if (hb.host_read !== ((w >= 0) && !efull)) begin
                errors++; $display("FAIL rnd_host_read c%0d got %b exp %b", c, hb.host_read, (w >= 0) && !efull); end
            if (w >= 0) begin
                for (int i = 0; i < NR; i++) ewr[i] = (i != w) || hb.host_waitrequest || efull;
                checks++; if (hb.host_address !== addr_of(w) || hb.host_burstcount !== bc_of(w) || req_waitrequest !== ewr) begin
                    errors++; $display("FAIL rnd_cmd c%0d got %h/%0d/%b exp %h/%0d/%b", c, hb.host_address, hb.host_burstcount, req_waitrequest, addr_of(w), bc_of(w), ewr); end
            end
            cycle();
            if (m_acc >= 0) req_read[m_acc] = 1'b0;
            checks++; if (req_readdatavalid !== exp_rdv || req_readdata !== exp_data || err_unexpected_rsp !== exp_err) begin
                errors++; $display("FAIL rnd_rsp c%0d got %b/%h/%b exp %b/%h/%b", c, req_readdatavalid, req_readdata, err_unexpected_rsp, exp_rdv, exp_data, exp_err); end
        end
        hb.host_readdatavalid = 1'b0;
        hb.host_waitrequest   = 1'b0;
        req_read = '0;
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_stall_hold();
        test_full();
        test_interleave();
        test_reset_mid();
        test_stats();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
